serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It sequences one one-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first, with a carry flip-flop closing the loop between cycles. It sits between a requester (start/ready handshake) and the full-adder datapath, so multi-bit adds cost one adder cell instead of a ripple chain.

---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_if.sv | 28 ++
 rtl/serial_add_ctrl_fa.sv | 14 +
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and limits for the bit-serial adder controller.
// Holds the controller state encoding and the legal operand-width range.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MIN_WIDTH = 32'd2;
  localparam int unsigned MAX_WIDTH = 32'd64;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and result bus of the bit-serial adder.
// The requester drives operands and start; the controller returns status and result.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 32'd8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, ovf
  );

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder cell shared by every bit position of the serial add.
// Purely combinational; the carry loop is closed by a flop in the controller.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule : fa

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB first over WIDTH cycles.
// Accepts a request in IDLE, shifts operands through the cell in RUN, pulses done in DONE.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 32'd1);
  localparam logic [CNT_W-1:0] CNT_PREMSB = CNT_W'(WIDTH - 32'd2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

  if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of legal range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             cell_s;
  logic             cell_c;

  fa u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (cell_s),
    .co_o (cell_c)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {cell_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = cell_c;

        // Carry out of bit WIDTH-2 is the carry into the MSB, needed for ovf.
        if (cnt_q == CNT_PREMSB) begin
          c_msb_d = cell_c;
        end else begin
          c_msb_d = c_msb_q;
        end

        if (cnt_q == CNT_LAST) begin
          cnt_d   = cnt_q;
          sum_d   = {cell_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = cell_c;
          ovf_d   = cell_c ^ c_msb_q;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift, counter and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      sum_sh_q <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      sum_q    <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8, checked against plain integer arithmetic.
module tb_serial_add_ctrl;

  localparam int unsigned W = 32'd8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // One add through the handshake; noisy keeps start high with junk operands until the DONE cycle ends.
  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input bit noisy, input string tag);
    logic [8:0] full;
    logic       e_ovf;
    int         lat;
    int         bc;
    bit         seen;
    full  = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tc};
    e_ovf = (ta[7] == tb_v[7]) && (full[7] != ta[7]);
    @(negedge clk);
    chk({tag, ".ready_pre"}, {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.cin = tc;
    @(posedge clk);
    @(negedge clk);
    if (noisy) begin
      bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    end else begin
      bus.start = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
    end
    lat = 0; bc = 0; seen = 1'b0;
    while ((lat < 20) && !seen) begin
      if (bus.busy) bc++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
        if (!noisy) begin
          bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
        end
      end
    end
    chk({tag, ".done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, ".latency"}, lat, 32'd8);
    chk({tag, ".busy_cycles"}, bc, 32'd8);
    chk({tag, ".sum"}, {24'd0, bus.sum}, {24'd0, full[7:0]});
    chk({tag, ".cout"}, {31'd0, bus.cout}, {31'd0, full[8]});
    chk({tag, ".ovf"}, {31'd0, bus.ovf}, {31'd0, e_ovf});
    chk({tag, ".ready_in_done"}, {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, ".done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, bus.ready}, 32'd1);
    chk({tag, ".sum_held"}, {24'd0, bus.sum}, {24'd0, full[7:0]});
    if (noisy) begin
      @(negedge clk);
      chk({tag, ".no_second_run"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, ".sum_still"}, {24'd0, bus.sum}, {24'd0, full[7:0]});
    end
  endtask

  initial begin
    int  dcnt;
    int  bcnt;
    int  last_done;
    bit  stray;
    logic [7:0] ra;
    logic [7:0] rb;

    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst.ready", {31'd0, bus.ready}, 32'd1);
      chk("rst.busy", {31'd0, bus.busy}, 32'd0);
      chk("rst.done", {31'd0, bus.done}, 32'd0);
      chk("rst.result", {22'd0, bus.sum, bus.cout, bus.ovf}, 32'd0);
    end

    do_add(8'h3C, 8'h5A, 1'b0, 1'b0, "add3c5a");
    do_add(8'hFF, 8'h01, 1'b0, 1'b0, "addff01");
    do_add(8'h80, 8'h80, 1'b0, 1'b0, "add8080");
    do_add(8'h00, 8'h00, 1'b1, 1'b0, "cin_only");
    do_add(8'h01, 8'h01, 1'b0, 1'b1, "ignored_start");

    // Reset on the fourth RUN cycle aborts the add and clears the result
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h7F; bus.b = 8'h01; bus.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.ready", {31'd0, bus.ready}, 32'd1);
    chk("abort.busy", {31'd0, bus.busy}, 32'd0);
    chk("abort.done", {31'd0, bus.done}, 32'd0);
    chk("abort.result", {22'd0, bus.sum, bus.cout, bus.ovf}, 32'd0);
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray = 1'b1;
    end
    chk("abort.no_done", {31'd0, stray}, 32'd0);
    do_add(8'h10, 8'h20, 1'b0, 1'b0, "after_abort");

    // Continuous start: one add per 10 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0;
    @(posedge clk);
    dcnt = 0; bcnt = 0; last_done = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        chk("stream.sum", {24'd0, bus.sum}, 32'h33);
        if (last_done >= 0) chk("stream.period", i - last_done, 32'd10);
        else chk("stream.first_lat", i, 32'd8);
        last_done = i;
        dcnt++;
      end
    end
    bus.start = 1'b0;
    chk("stream.done_count", dcnt, 32'd4);
    chk("stream.busy_count", bcnt, 32'd32);
    repeat (12) @(negedge clk);

    // Randomized operands against integer arithmetic
    for (int k = 0; k < 12; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_add(ra, rb, 1'($urandom), 1'b0, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_add_ctrl
